// File: rtl/jar_sram_pkg.sv
// Shared constants, state encoding and pin helpers for the nibble-serial SRAM sequencer.
package jar_sram_pkg;

    localparam int PIN_CLK     = 0;
    localparam int PIN_RST     = 1;
    localparam int PIN_WE      = 2;
    localparam int PIN_OE      = 3;
    localparam int PIN_NIB_LSB = 4;

    typedef enum logic [3:0] {
        INIT_L, INIT_H, IDLE,
        WLO_L, WLO_H, WHI_L, WHI_H, WADR_L, WADR_H,
        RD_L, RD_H, RD_CAP
    } state_t;

    // Control pins {oe, we, rst, clk}; each _H phase is its _L phase with the SRAM clock raised.
    localparam logic [3:0] CTL_CLK    = 4'(1 << PIN_CLK);
    localparam logic [3:0] CTL_IDLE   = 4'h0;
    localparam logic [3:0] CTL_INIT_L = 4'(1 << PIN_RST);
    localparam logic [3:0] CTL_INIT_H = CTL_INIT_L | CTL_CLK;
    localparam logic [3:0] CTL_WR_L   = 4'(1 << PIN_WE);
    localparam logic [3:0] CTL_WR_H   = CTL_WR_L | CTL_CLK;
    localparam logic [3:0] CTL_RD_L   = 4'(1 << PIN_OE);
    localparam logic [3:0] CTL_RD_H   = CTL_RD_L | CTL_CLK;

    function automatic logic [7:0] make_pins(input logic [3:0] nib, input logic [3:0] ctl);
        logic [7:0] p;
        p = 8'h00;
        p[PIN_NIB_LSB +: 4]    = nib;
        p[PIN_NIB_LSB - 1 : 0] = ctl;
        return p;
    endfunction

endpackage

// File: rtl/jar_sram_rr_arb.sv
// Round-robin arbiter: the requester after the last granted one has top priority.
module jar_sram_rr_arb #(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] valid,
    input  logic            advance,
    output logic [NREQ-1:0] grant
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0] last;
    logic [IW-1:0] pick;
    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        grant = '0;
        pick  = last;
        cand  = last;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last) + k) % NREQ);
            if (!found && valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                pick        = cand;
            end
        end
    end

    // Pointer starts on the highest index so requester 0 wins the first contest.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= IW'(NREQ - 1);
        end else if (advance) begin
            last <= pick;
        end
    end

endmodule

// File: rtl/jar_sram_ctrl.sv
// Arbitrates byte requests and bit-bangs the nibble-serial SRAM tile as two-cycle ticks.
import jar_sram_pkg::*;

module jar_sram_ctrl #(
    parameter int NREQ = 2,
    parameter int AW   = 3,
    parameter int DW   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_rdata,
    output logic [7:0]         sram_in,
    input  logic [7:0]         sram_out
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state;
    state_t          state_nx;
    logic [NREQ-1:0] grant;
    logic            grant_any;
    logic [IW-1:0]   g_idx;
    logic            g_we;
    logic [AW-1:0]   g_addr;
    logic [DW-1:0]   g_wdata;
    logic [IW-1:0]   own_q;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [AW-1:0]   cur_addr;
    logic [DW-1:0]   cur_wdata;
    logic [NREQ-1:0] own_oh;
    logic [7:0]      pins_nx;

    jar_sram_rr_arb #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid   (req_valid),
        .advance (grant_any),
        .grant   (grant)
    );

    assign grant_any = (state == IDLE) && !rst && (|req_valid);
    assign req_ready = grant_any ? grant : '0;
    assign own_oh    = NREQ'(1) << own_q;

    always_comb begin
        g_idx   = '0;
        g_we    = 1'b0;
        g_addr  = '0;
        g_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                g_idx   = IW'(i);
                g_we    = req_we[i];
                g_addr  = req_addr[i*AW +: AW];
                g_wdata = req_wdata[i*DW +: DW];
            end
        end
    end

    // Pins are registered from the next state, so the grant cycle must see the new request fields.
    assign cur_addr  = grant_any ? g_addr  : addr_q;
    assign cur_wdata = grant_any ? g_wdata : wdata_q;

    always_comb begin
        state_nx = state;
        case (state)
            INIT_L:  state_nx = INIT_H;
            INIT_H:  state_nx = IDLE;
            IDLE:    if (grant_any) state_nx = g_we ? WLO_L : RD_L;
            WLO_L:   state_nx = WLO_H;
            WLO_H:   state_nx = WHI_L;
            WHI_L:   state_nx = WHI_H;
            WHI_H:   state_nx = WADR_L;
            WADR_L:  state_nx = WADR_H;
            WADR_H:  state_nx = IDLE;
            RD_L:    state_nx = RD_H;
            RD_H:    state_nx = RD_CAP;
            RD_CAP:  state_nx = IDLE;
            default: state_nx = INIT_L;
        endcase
    end

    always_comb begin
        pins_nx = make_pins(4'h0, CTL_IDLE);
        case (state_nx)
            INIT_L: pins_nx = make_pins(4'h0, CTL_INIT_L);
            INIT_H: pins_nx = make_pins(4'h0, CTL_INIT_H);
            WLO_L:  pins_nx = make_pins(cur_wdata[3:0], CTL_WR_L);
            WLO_H:  pins_nx = make_pins(cur_wdata[3:0], CTL_WR_H);
            WHI_L:  pins_nx = make_pins(cur_wdata[7:4], CTL_WR_L);
            WHI_H:  pins_nx = make_pins(cur_wdata[7:4], CTL_WR_H);
            WADR_L: pins_nx = make_pins({1'b0, cur_addr}, CTL_WR_L);
            WADR_H: pins_nx = make_pins({1'b0, cur_addr}, CTL_WR_H);
            RD_L:   pins_nx = make_pins({1'b0, cur_addr}, CTL_RD_L);
            RD_H:   pins_nx = make_pins({1'b0, cur_addr}, CTL_RD_H);
            RD_CAP: pins_nx = make_pins({1'b0, cur_addr}, CTL_RD_L);
            default: pins_nx = make_pins(4'h0, CTL_IDLE);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT_L;
            sram_in   <= make_pins(4'h0, CTL_INIT_L);
            rsp_valid <= '0;
            rsp_rdata <= '0;
            own_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state     <= state_nx;
            sram_in   <= pins_nx;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            if (grant_any) begin
                own_q   <= g_idx;
                we_q    <= g_we;
                addr_q  <= g_addr;
                wdata_q <= g_wdata;
            end
            if (state == WADR_H) begin
                rsp_valid <= own_oh;
            end
            // The SRAM has been driving the byte since the RD_H rising edge.
            if (state == RD_CAP) begin
                rsp_valid <= own_oh;
                rsp_rdata <= sram_out;
            end
        end
    end

endmodule

// File: tb/tb_jar_sram_ctrl.sv
// Bench for jar_sram_ctrl: SRAM tile model, per-requester drivers, scoreboard monitor, summary.
module tb_jar_sram_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hold_all = 1'b1;
    logic        mon_en = 1'b0;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [5:0]  req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [7:0]  sram_in;
    logic [7:0]  sram_out;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [41:0] exp_q[$];   // {due cycle[31:0], owner one-hot[1:0], rdata[7:0]}
    int          grant_log[$];
    logic [3:0]  wr_nibs[$];

    logic [7:0] ref_mem  [8] = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5, 8'hE6, 8'hE7};
    logic [7:0] tile_mem [8] = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5, 8'hE6, 8'hE7};
    logic [1:0] tile_cnt  = 2'd0;
    logic [3:0] tile_lo   = 4'h0;
    logic [3:0] tile_hi   = 4'h0;
    logic [7:0] tile_dout = 8'h00;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    jar_sram_ctrl #(.NREQ(2), .AW(3), .DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .sram_in   (sram_in),
        .sram_out  (sram_out)
    );

    // ---------------- SRAM tile model ----------------
    // Write ticks deliver low nibble, high nibble, then address; read ticks present the addressed byte.
    always @(posedge sram_in[0]) begin
        if (sram_in[1]) begin
            tile_cnt <= 2'd0;
        end else if (sram_in[2]) begin
            wr_nibs.push_back(sram_in[7:4]);
            case (tile_cnt)
                2'd0: begin tile_lo <= sram_in[7:4]; tile_cnt <= 2'd1; end
                2'd1: begin tile_hi <= sram_in[7:4]; tile_cnt <= 2'd2; end
                default: begin
                    tile_mem[sram_in[6:4]] <= {tile_hi, tile_lo};
                    tile_cnt <= 2'd0;
                end
            endcase
        end else if (sram_in[3]) begin
            tile_dout <= tile_mem[sram_in[6:4]];
        end
    end
    assign sram_out = tile_dout;

    // ---------------- requester drivers ----------------
    for (genvar g = 0; g < 2; g++) begin : drv
        logic        valid = 1'b0;
        logic        we    = 1'b0;
        logic [2:0]  addr  = 3'd0;
        logic [7:0]  wdata = 8'h00;
        logic        busy  = 1'b0;
        logic [14:0] cmd_q[$];   // {delay[2:0], we, addr[2:0], data[7:0]}

        initial begin
            logic [14:0] c;
            int t;
            @(negedge clk);
            forever begin
                if (cmd_q.size() == 0) begin
                    @(negedge clk);
                end else begin
                    c = cmd_q.pop_front();
                    busy = 1'b1;
                    repeat (int'(c[14:12])) @(negedge clk);
                    we = c[11]; addr = c[10:8]; wdata = c[7:0]; valid = 1'b1;
                    #1;
                    t = 0;
                    while (!req_ready[g] && t < 300) begin
                        @(negedge clk); #1; t++;
                    end
                    @(negedge clk);
                    valid = 1'b0;
                    busy = 1'b0;
                end
            end
        end
    end

    assign req_valid = {drv[1].valid, drv[0].valid} | {2{hold_all}};
    assign req_we    = {drv[1].we, drv[0].we};
    assign req_addr  = {drv[1].addr, drv[0].addr};
    assign req_wdata = {drv[1].wdata, drv[0].wdata};

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic push_cmd(input int r, input int dly, input int we, input int a, input int d);
        logic [14:0] c;
        c = {3'(dly), 1'(we), 3'(a), 8'(d)};
        if (r == 0) drv[0].cmd_q.push_back(c);
        else        drv[1].cmd_q.push_back(c);
    endtask

    task automatic wait_done(input string nm);
        int t;
        t = 0;
        while ((drv[0].cmd_q.size() != 0 || drv[1].cmd_q.size() != 0 || drv[0].busy ||
                drv[1].busy || exp_q.size() != 0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check(nm, 64'(t < 2000), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [41:0] e;
        int          g;
        logic [2:0]  a;
        logic [7:0]  dexp;
        logic [2:0]  pend_addr;
        logic [7:0]  pend_old;
        logic        pend_we;
        pend_addr = 3'd0; pend_old = 8'h00; pend_we = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (exp_q.size() != 0 && cyc >= int'(exp_q[0][41:10])) begin
                    e = exp_q.pop_front();
                    check("rsp_owner", 64'(rsp_valid), 64'(e[9:8]));
                    check("rsp_rdata", 64'(rsp_rdata), 64'(e[7:0]));
                end else if (rsp_valid != 2'b00) begin
                    check("rsp_unexpected", 64'(rsp_valid), 64'd0);
                end
                check("oe_we_excl", 64'(sram_in[3] & sram_in[2]), 64'd0);
                check("pin7_low", 64'(!sram_in[2] & sram_in[7]), 64'd0);
                check("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
            end
            #2;
            if (mon_en && req_ready != 2'b00) begin
                g = req_ready[1] ? 1 : 0;
                a = req_addr[g*3 +: 3];
                pend_addr = a;
                pend_we   = req_we[g];
                if (req_we[g]) begin
                    pend_old  = ref_mem[a];
                    ref_mem[a] = req_wdata[g*8 +: 8];
                    dexp = 8'h00;
                    e[41:10] = 32'(cyc + 7);
                end else begin
                    dexp = ref_mem[a];
                    e[41:10] = 32'(cyc + 4);
                end
                e[9:8] = (g == 1) ? 2'b10 : 2'b01;
                e[7:0] = dexp;
                exp_q.push_back(e);
                grant_log.push_back(g);
            end
            // A reset aborts the request in flight: it never completes and never lands in memory.
            if (rst && exp_q.size() != 0) begin
                if (pend_we) ref_mem[pend_addr] = pend_old;
                exp_q.delete();
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int s;
        int gs;
        repeat (3) begin
            @(negedge clk);
            check("rst_pins", 64'(sram_in), 64'h02);
            check("rst_ready", 64'(req_ready), 64'd0);
            check("rst_rsp", 64'(rsp_valid), 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("init_h_pins", 64'(sram_in), 64'h03);
        check("init_h_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("idle_pins", 64'(sram_in), 64'h00);
        check("idle_grant_req0", 64'(req_ready), 64'h1);
        hold_all = 1'b0;
        #1;
        check("idle_drop_ready", 64'(req_ready), 64'd0);
        mon_en = 1'b1;
        repeat (3) @(negedge clk);

        // write addr 5 = A7 then read it back, requester 0
        s = wr_nibs.size();
        @(posedge clk);
        push_cmd(0, 0, 1, 5, 8'hA7);
        wait_done("wr_a7_done");
        check("wr_nib_count", 64'(wr_nibs.size()), 64'(s + 3));
        check("wr_nib_lo", 64'(wr_nibs[s]), 64'h7);
        check("wr_nib_hi", 64'(wr_nibs[s+1]), 64'hA);
        check("wr_nib_adr", 64'(wr_nibs[s+2]), 64'h5);
        @(posedge clk);
        push_cmd(0, 0, 0, 5, 0);
        wait_done("rd_a7_done");

        // contention: requester 1 was granted last, so requester 0 leads
        @(posedge clk);
        push_cmd(1, 0, 1, 1, 8'h99);
        wait_done("pre_contention_done");
        gs = grant_log.size();
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            push_cmd(0, 0, 0, 1, 0);
            push_cmd(1, 0, 1, 2, 8'h3C);
        end
        wait_done("contention_done");
        check("contention_count", 64'(grant_log.size()), 64'(gs + 8));
        for (int i = 0; i < 8; i++) check("contention_grant", 64'(grant_log[gs+i]), 64'(i % 2));

        // reset during WHI_H of a write to addr 5
        s = wr_nibs.size();
        @(posedge clk);
        push_cmd(0, 0, 1, 5, 8'hFF);
        gs = 0;
        while (wr_nibs.size() < s + 2 && gs < 100) begin
            @(negedge clk);
            gs++;
        end
        check("whi_h_pins", 64'(sram_in), 64'hF5);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_pins", 64'(sram_in), 64'h02);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        push_cmd(0, 0, 1, 0, 8'h55);
        push_cmd(0, 0, 0, 0, 0);
        push_cmd(0, 0, 0, 5, 0);
        wait_done("post_rst_done");

        // back-to-back fill and readback
        @(posedge clk);
        for (int a = 0; a < 8; a++) push_cmd(0, 0, 1, a, 8'h10 + a);
        wait_done("fill_wr_done");
        @(posedge clk);
        for (int a = 0; a < 8; a++) push_cmd($urandom_range(0, 1), 0, 0, a, 0);
        wait_done("fill_rd_done");

        // randomized mixed traffic from both requesters
        @(posedge clk);
        for (int i = 0; i < 30; i++) begin
            push_cmd(0, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 255));
            push_cmd(1, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 255));
        end
        wait_done("random_done");

        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
